// File: rtl/rounds_if.sv
// Bus between the AES-128 round datapath, its key scheduler and the output stage.
// master drives the request side (start, plain_text, round_key); slave is the round datapath.
interface rounds_if;
  logic         start;
  logic [0:127] plain_text;
  logic [0:127] round_key;
  logic [0:127] enc_data;
  logic [3:0]   round_num;
  logic         valid_flag;

  modport master (
    output start, plain_text, round_key,
    input  enc_data, round_num, valid_flag
  );

  modport slave (
    input  start, plain_text, round_key,
    output enc_data, round_num, valid_flag
  );
endinterface

// File: rtl/rounds.sv
// Iterative AES-128 encryption: AddRoundKey on start, then one cipher round per clock.
// Optional debug port state_out is enabled by defining ROUNDS_STATE_OUT_EN.
module rounds (
  input  logic    clk,
  input  logic    reset_n,
  rounds_if.slave bus
`ifdef ROUNDS_STATE_OUT_EN
  ,
  output logic [0:127] state_out
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t         fsm_reg, fsm_next;
  logic [0:127] state_reg, state_next;
  logic [0:127] enc_reg, enc_next;
  logic [3:0]   round_reg, round_next;
  logic         valid_reg, valid_next;
  logic [0:127] round_out;
  logic         final_round;
  logic         load;

  logic [7:0] sub_b   [16];
  logic [7:0] shift_b [16];
  logic [7:0] mix_b   [16];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] s;
    s = 8'h00;
    case (b)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  assign final_round = (round_reg == 4'd10);
  assign load        = bus.start && (fsm_reg != RUN);

  // Byte k sits at row k%4, column k/4; ShiftRows pulls row r from column (c+r)%4.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
      assign sub_b[gi]   = sbox(state_reg[8*gi +: 8]);
      assign shift_b[gi] = sub_b[(gi % 4) + 4 * (((gi / 4) + (gi % 4)) % 4)];
      assign round_out[8*gi +: 8] = (final_round ? shift_b[gi] : mix_b[gi])
                                    ^ bus.round_key[8*gi +: 8];
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_mix
      logic [7:0] a0, a1, a2, a3;
      assign a0 = shift_b[4*gi + 0];
      assign a1 = shift_b[4*gi + 1];
      assign a2 = shift_b[4*gi + 2];
      assign a3 = shift_b[4*gi + 3];
      assign mix_b[4*gi + 0] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      assign mix_b[4*gi + 1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      assign mix_b[4*gi + 2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      assign mix_b[4*gi + 3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  endgenerate

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      fsm_reg   <= IDLE;
      state_reg <= '0;
      enc_reg   <= '0;
      round_reg <= 4'd0;
      valid_reg <= 1'b0;
    end else begin
      fsm_reg   <= fsm_next;
      state_reg <= state_next;
      enc_reg   <= enc_next;
      round_reg <= round_next;
      valid_reg <= valid_next;
    end
  end

  always_comb begin
    fsm_next = fsm_reg;
    case (fsm_reg)
      IDLE:    if (bus.start) fsm_next = RUN;
      RUN:     if (final_round) fsm_next = DONE;
      DONE:    if (bus.start) fsm_next = RUN;
      default: fsm_next = IDLE;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    enc_next   = enc_reg;
    round_next = round_reg;
    valid_next = valid_reg;
    if (load) begin
      state_next = bus.plain_text ^ bus.round_key;
      round_next = 4'd1;
      valid_next = 1'b0;
    end else if (fsm_reg == RUN) begin
      state_next = round_out;
      if (final_round) begin
        enc_next   = round_out;
        valid_next = 1'b1;
      end else begin
        round_next = round_reg + 4'd1;
      end
    end
  end

  assign bus.enc_data   = enc_reg;
  assign bus.round_num  = round_reg;
  assign bus.valid_flag = valid_reg;

`ifdef ROUNDS_STATE_OUT_EN
  assign state_out = state_reg;
`endif

endmodule

// File: tb/tb_rounds.sv
// Self-checking bench for rounds: acts as key scheduler and compares against an AES-128 model.
// The model derives the S-box from GF(2^8) inversion plus the affine map.
module tb_rounds;
  logic clk = 1'b0;
  logic reset_n;
  rounds_if bus();

`ifdef ROUNDS_STATE_OUT_EN
  logic [0:127] state_out;
  rounds dut (.clk(clk), .reset_n(reset_n), .bus(bus), .state_out(state_out));
`else
  rounds dut (.clk(clk), .reset_n(reset_n), .bus(bus));
`endif

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_tab [256];
  logic [0:127] rk [11];

  // Scheduler: key 0 is presented in DONE so a restart edge sees the cipher key.
  always_comb begin
    if (bus.valid_flag || bus.round_num > 4'd10) bus.round_key = rk[0];
    else                                         bus.round_key = rk[bus.round_num];
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [0:127] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t[31:24] = t[31:24] ^ rcon;
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [0:127] aes_ref(input logic [0:127] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [0:127] k;
    logic [0:127] out;
    k = rk[0];
    for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ k[8*i +: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_tab[s[i]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[w + 4*c] = s[w + 4*((c + w) % 4)];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          if (r < 10)
            s[w + 4*c] = gmul(8'h02, t[w + 4*c]) ^ gmul(8'h03, t[(w+1)%4 + 4*c])
                         ^ t[(w+2)%4 + 4*c] ^ t[(w+3)%4 + 4*c];
          else
            s[w + 4*c] = t[w + 4*c];
      k = rk[r];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[8*i +: 8];
    end
    for (int i = 0; i < 16; i++) out[8*i +: 8] = s[i];
    return out;
  endfunction

  function automatic logic [0:127] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One full encryption; optionally pulses start with other data when round_num hits inject.
  task automatic run_block(input string name, input logic [0:127] pt, input logic [0:127] key,
                           input logic [0:127] exp, input int inject);
    expand(key);
    @(negedge clk);
    bus.plain_text = pt;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({name, " round_num after start"}, 128'(bus.round_num), 128'd1);
    check({name, " valid after start"}, 128'(bus.valid_flag), 128'd0);
    for (int e = 1; e <= 9; e++) begin
      if (inject != 0 && int'(bus.round_num) == inject) begin
        bus.start      = 1'b1;
        bus.plain_text = ~pt;
      end
      @(negedge clk);
      bus.start = 1'b0;
      check($sformatf("%s round_num edge %0d", name, e), 128'(bus.round_num), 128'(e + 1));
      check($sformatf("%s valid edge %0d", name, e), 128'(bus.valid_flag), 128'd0);
    end
    @(negedge clk);
    check({name, " valid"}, 128'(bus.valid_flag), 128'd1);
    check({name, " enc_data"}, bus.enc_data, exp);
    check({name, " round_num hold"}, 128'(bus.round_num), 128'd10);
    $display("%s pt=%h key=%h ct=%h valid=%0b", name, pt, key, bus.enc_data, bus.valid_flag);
  endtask

  initial begin
    logic [0:127] pt, key, exp;
    build_sbox();
    expand(128'h0);
    reset_n        = 1'b1;
    bus.start      = 1'b0;
    bus.plain_text = '0;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.start      = 1'($urandom);
      bus.plain_text = rand128();
    end
    check("reset enc_data", bus.enc_data, 128'd0);
    check("reset round_num", 128'(bus.round_num), 128'd0);
    check("reset valid", 128'(bus.valid_flag), 128'd0);
`ifdef ROUNDS_STATE_OUT_EN
    check("reset state_out", state_out, 128'd0);
`endif
    $display("reset held with toggled inputs");
    bus.start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;

    run_block("zero_key", 128'h00000101030307070f0f1f1f3f3f7f7f, 128'h0,
              128'hc7d12419489e3b6233a2c5a7f4563172, 5);
    run_block("fips_c1_restart", 128'h00112233445566778899aabbccddeeff,
              128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0);

    for (int n = 0; n < 6; n++) begin
      pt  = rand128();
      key = rand128();
      expand(key);
      exp = aes_ref(pt);
      run_block($sformatf("random%0d", n), pt, key, exp, (n % 2 == 0) ? 3 + n : 0);
    end

    // Abort mid-run: outputs must clear at once and no result may ever be flagged.
    expand(128'h0);
    @(negedge clk);
    bus.plain_text = rand128();
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("abort enc_data", bus.enc_data, 128'd0);
    check("abort round_num", 128'(bus.round_num), 128'd0);
    check("abort valid", 128'(bus.valid_flag), 128'd0);
    @(negedge clk);
    reset_n = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      check($sformatf("abort valid cycle %0d", i), 128'(bus.valid_flag), 128'd0);
    end
    check("abort enc_data after", bus.enc_data, 128'd0);
    $display("abort mid-run reset done");

    run_block("fips_c1_after_abort", 128'h00112233445566778899aabbccddeeff,
              128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
